// File: rtl/mem_access_if.sv
// Groups the MEM-stage request, writeback handshake and data-cache signals.
// Combinational bundle only; no latency of its own.
// Backpressure is carried by req_ready (request side) and wb_ready (result side).
interface mem_access_if #(parameter int XLEN = 32);
  localparam int NBYTES = XLEN / 8;

  logic              req_valid;
  logic              req_read;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              req_ready;
  logic              flush;
  logic              wb_ready;
  logic              mem_resp_d;
  logic [XLEN-1:0]   mem_rdata_d;
  logic              mem_r_d;
  logic              mem_w_d;
  logic [XLEN-1:0]   mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_d;
  logic [NBYTES-1:0] mem_byte_en_d;
  logic              mem_rdy;
  logic [XLEN-1:0]   load_data;
  logic              exc;
  logic [1:0]        exc_code;

  // Pipeline / cache side that drives requests and responses.
  modport master (
    output req_valid, req_read, req_write, req_funct3, req_addr, req_wdata,
    output flush, wb_ready, mem_resp_d, mem_rdata_d,
    input  req_ready, mem_r_d, mem_w_d, mem_addr_d, mem_wdata_d, mem_byte_en_d,
    input  mem_rdy, load_data, exc, exc_code
  );

  // The access unit itself.
  modport slave (
    input  req_valid, req_read, req_write, req_funct3, req_addr, req_wdata,
    input  flush, wb_ready, mem_resp_d, mem_rdata_d,
    output req_ready, mem_r_d, mem_w_d, mem_addr_d, mem_wdata_d, mem_byte_en_d,
    output mem_rdy, load_data, exc, exc_code
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: aligns, lane-shifts, checks faults and extends load data.
// Latency: cache request the cycle after accept; result in the cycle after mem_resp_d (faults: next cycle).
// Backpressure: req_ready low during a cache access, or while a result is held without wb_ready.
module mem_access_unit #(
  parameter int XLEN = 32
) (
  input logic         clk,
  input logic         rst,
  mem_access_if.slave bus
);
  localparam int NBYTES = XLEN / 8;
  localparam int OFFW   = $clog2(NBYTES);

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

  state_t              state, state_nxt;
  logic                accept;
  logic                illegal, misalign;
  logic [1:0]          code_in;
  logic [NBYTES-1:0]   mask_in;
  logic [OFFW-1:0]     off_in;
  logic [XLEN-1:0]     shifted, ext;

  logic                op_read;
  logic [2:0]          funct3_q;
  logic [OFFW-1:0]     off_q;
  logic [XLEN-1:0]     addr_q, wdata_q, load_q;
  logic [NBYTES-1:0]   be_q;
  logic                exc_q;
  logic [1:0]          code_q;
  logic                drop_q;

  // Decode the incoming request: width mask, illegal width and misalignment.
  always_comb begin
    off_in   = bus.req_addr[OFFW-1:0];
    // A request with both read and write set is a load, so only a pure store rejects funct3 >= 100.
    illegal  = (bus.req_funct3 == 3'b111) || (!bus.req_read && bus.req_funct3[2]) ||
               (XLEN == 32 && (bus.req_funct3 == 3'b011 || bus.req_funct3 == 3'b110));
    misalign = 1'b0;
    mask_in  = NBYTES'(8'h01);
    case (bus.req_funct3[1:0])
      2'd0: begin misalign = 1'b0;                        mask_in = NBYTES'(8'h01); end
      2'd1: begin misalign = bus.req_addr[0];             mask_in = NBYTES'(8'h03); end
      2'd2: begin misalign = bus.req_addr[1:0] != 2'b00;  mask_in = NBYTES'(8'h0F); end
      default: begin misalign = bus.req_addr[2:0] != 3'b000; mask_in = NBYTES'(8'hFF); end
    endcase
    // Illegal width outranks misalignment.
    code_in = illegal ? 2'b11 : (misalign ? (bus.req_read ? 2'b01 : 2'b10) : 2'b00);
  end

  // Bring the addressed bytes down to lane 0, then truncate and sign/zero extend.
  always_comb begin
    shifted = bus.mem_rdata_d >> {off_q, 3'b000};
    case (funct3_q[1:0])
      2'd0:    ext = funct3_q[2] ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
      2'd1:    ext = funct3_q[2] ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
      2'd2:    ext = funct3_q[2] ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
      default: ext = shifted;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state plus handshake and cache-request outputs.
  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    bus.mem_r_d   = 1'b0;
    bus.mem_w_d   = 1'b0;
    bus.mem_rdy   = 1'b0;
    bus.exc       = 1'b0;
    bus.exc_code  = 2'b00;
    accept        = 1'b0;
    if (rst && !bus.flush && (state == IDLE || (state == HOLD && bus.wb_ready)))
      bus.req_ready = 1'b1;
    accept = bus.req_ready && bus.req_valid && (bus.req_read || bus.req_write);
    case (state)
      IDLE: begin
        if (accept) state_nxt = (code_in != 2'b00) ? HOLD : ACCESS;
      end
      ACCESS: begin
        bus.mem_r_d = op_read;
        bus.mem_w_d = !op_read;
        // A flushed access still waits for the cache, then disappears.
        if (bus.mem_resp_d) state_nxt = (drop_q || bus.flush) ? IDLE : HOLD;
      end
      HOLD: begin
        bus.mem_rdy  = 1'b1;
        bus.exc      = exc_q;
        bus.exc_code = code_q;
        if (bus.flush)         state_nxt = IDLE;
        else if (bus.wb_ready) state_nxt = accept ? ((code_in != 2'b00) ? HOLD : ACCESS) : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the formatted request at accept and capture the load result on response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_read  <= 1'b0;
      funct3_q <= 3'b000;
      off_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      load_q   <= '0;
      exc_q    <= 1'b0;
      code_q   <= 2'b00;
      drop_q   <= 1'b0;
    end else if (accept) begin
      op_read  <= bus.req_read;
      funct3_q <= bus.req_funct3;
      off_q    <= off_in;
      addr_q   <= {bus.req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
      wdata_q  <= bus.req_wdata << {off_in, 3'b000};
      be_q     <= mask_in << off_in;
      load_q   <= '0;
      exc_q    <= code_in != 2'b00;
      code_q   <= code_in;
      drop_q   <= 1'b0;
    end else if (state == ACCESS) begin
      if (bus.flush) drop_q <= 1'b1;
      if (bus.mem_resp_d && !drop_q && !bus.flush) load_q <= op_read ? ext : '0;
    end
  end

  assign bus.mem_addr_d    = addr_q;
  assign bus.mem_wdata_d   = wdata_q;
  assign bus.mem_byte_en_d = be_q;
  assign bus.load_data     = load_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized traffic against a transaction model.
// Inputs change on the falling edge; outputs are sampled 1-2 time units later.
// Backpressure is exercised through random wb_ready, flush, response delay and reset pulses.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_if #(.XLEN(32)) b();
  mem_access_if #(.XLEN(64)) b64();

  mem_access_unit #(.XLEN(32)) dut   (.clk(clk), .rst(rst_n), .bus(b));
  mem_access_unit #(.XLEN(64)) dut64 (.clk(clk), .rst(rst_n), .bus(b64));

  int n_chk = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: gather the addressed bytes one by one, then extend.
  function automatic logic [31:0] exp_load(logic [2:0] f3, logic [31:0] addr, logic [31:0] rd);
    int size = 1 << f3[1:0];
    int off = int'(addr[1:0]);
    logic [31:0] v = '0;
    logic [31:0] t;
    for (int i = 0; i < size; i++) begin
      t = rd >> (8 * (off + i));
      v = v | ({24'b0, t[7:0]} << (8 * i));
    end
    if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
    return v;
  endfunction

  function automatic logic [1:0] fault_code(bit rd, logic [2:0] f3, logic [31:0] addr);
    int size = 1 << f3[1:0];
    bit ill = (f3 == 3'd7) || (f3 == 3'd3) || (f3 == 3'd6) || (!rd && f3 >= 3'd4);
    bit mis = (addr % size) != 0;
    if (ill) return 2'b11;
    if (mis) return rd ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  // Transaction model of the 32-bit unit.
  bit          m_access, m_hold, m_clear, m_drop, m_read;
  logic [2:0]  m_f3;
  logic [31:0] m_addr, m_wdata, m_result;
  logic [1:0]  m_code;

  always @(negedge clk) begin
    bit exp_ready, acc;
    logic [31:0] e_wd, e_be;
    int off;
    #1;
    if (mon_en) begin
      if (!rst_n) begin
        m_access = 0; m_hold = 0; m_clear = 1; m_drop = 0;
      end
      exp_ready = rst_n && !b.flush && !m_access && (!m_hold || b.wb_ready);
      chk("req_ready", b.req_ready, exp_ready);
      chk("mem_r_d", b.mem_r_d, m_access && m_read);
      chk("mem_w_d", b.mem_w_d, m_access && !m_read);
      chk("mem_rdy", b.mem_rdy, m_hold);
      chk("exc", b.exc, m_hold && m_code != 0);
      chk("exc_code", b.exc_code, m_hold ? m_code : 2'b00);
      if (m_access) begin
        off  = int'(m_addr[1:0]);
        e_wd = m_wdata << (8 * off);
        e_be = ((32'd1 << (1 << m_f3[1:0])) - 1) << off;
        chk("mem_addr_d", b.mem_addr_d, m_addr & 32'hFFFF_FFFC);
        chk("mem_wdata_d", b.mem_wdata_d, e_wd);
        chk("mem_byte_en_d", b.mem_byte_en_d, e_be);
      end
      if (m_hold && m_code == 0) chk("load_data", b.load_data, m_result);
      if (m_clear) begin
        chk("clr_addr", b.mem_addr_d, 0);
        chk("clr_wdata", b.mem_wdata_d, 0);
        chk("clr_be", b.mem_byte_en_d, 0);
        chk("clr_load", b.load_data, 0);
      end
      if (rst_n) begin
        acc = exp_ready && b.req_valid && (b.req_read || b.req_write);
        if (m_access) begin
          if (b.flush) m_drop = 1;
          if (b.mem_resp_d) begin
            m_access = 0;
            if (!m_drop) begin
              m_hold = 1;
              m_result = m_read ? exp_load(m_f3, m_addr, b.mem_rdata_d) : 32'h0;
            end
          end
        end else begin
          if (m_hold && (b.flush || b.wb_ready)) m_hold = 0;
          if (acc) begin
            m_read = b.req_read; m_f3 = b.req_funct3;
            m_addr = b.req_addr; m_wdata = b.req_wdata;
            m_clear = 0; m_drop = 0;
            m_code = fault_code(b.req_read, b.req_funct3, b.req_addr);
            if (m_code != 0) m_hold = 1; else m_access = 1;
          end
        end
      end
    end
  end

  task automatic req32(bit v, bit rd, bit wr, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
    b.req_valid = v; b.req_read = rd; b.req_write = wr;
    b.req_funct3 = f3; b.req_addr = a; b.req_wdata = wd;
  endtask

  // One 64-bit transaction with an immediate cache response.
  task automatic do64(string name, bit rd, logic [2:0] f3, logic [63:0] a, logic [63:0] wd,
                      logic [63:0] rdata, logic [7:0] e_be, logic [63:0] e_wd, logic [63:0] e_ld);
    @(negedge clk);
    b64.req_valid = 1; b64.req_read = rd; b64.req_write = !rd;
    b64.req_funct3 = f3; b64.req_addr = a; b64.req_wdata = wd; b64.wb_ready = 1;
    #2 chk({name, "_ready"}, b64.req_ready, 1);
    @(negedge clk);
    b64.req_valid = 0; b64.mem_resp_d = 1; b64.mem_rdata_d = rdata;
    #2 chk({name, "_req"}, rd ? b64.mem_r_d : b64.mem_w_d, 1);
    chk({name, "_be"}, b64.mem_byte_en_d, e_be);
    chk({name, "_addr"}, b64.mem_addr_d, a & 64'hFFFF_FFFF_FFFF_FFF8);
    chk({name, "_wdata"}, b64.mem_wdata_d, e_wd);
    @(negedge clk);
    b64.mem_resp_d = 0;
    #2 chk({name, "_rdy"}, b64.mem_rdy, 1);
    chk({name, "_ld"}, b64.load_data, e_ld);
  endtask

  initial begin
    req32(0, 0, 0, 0, 0, 0);
    b.flush = 0; b.wb_ready = 0; b.mem_resp_d = 0; b.mem_rdata_d = 0;
    b64.req_valid = 0; b64.req_read = 0; b64.req_write = 0; b64.req_funct3 = 0;
    b64.req_addr = 0; b64.req_wdata = 0; b64.flush = 0; b64.wb_ready = 0;
    b64.mem_resp_d = 0; b64.mem_rdata_d = 0;
    m_access = 0; m_hold = 0; m_clear = 1; m_drop = 0; m_read = 0;
    m_f3 = 0; m_addr = 0; m_wdata = 0; m_result = 0; m_code = 0;

    // Pin the reference functions to hand-computed values.
    chk("model_lh", exp_load(3'd1, 32'h1002, 32'h8001_1234), 32'hFFFF_8001);
    chk("model_lbu", exp_load(3'd4, 32'h2001, 32'h0000_F000), 32'h0000_00F0);
    chk("model_fault", fault_code(1, 3'd2, 32'h1001), 2'b01);

    mon_en = 1;
    // Reset state.
    repeat (3) @(negedge clk);
    #2 chk("rst_ready", b.req_ready, 0);
    chk("rst_rdy", b.mem_rdy, 0);
    chk("rst_ready64", b64.req_ready, 0);
    @(negedge clk);
    rst_n = 1; b.wb_ready = 1;
    #2 chk("ready_after_rst", b.req_ready, 1);

    // 64-bit: LD, LW signed, LWU, SW in upper half.
    do64("ld64", 1, 3'd3, 64'h8, 64'h0, 64'h8123_4567_89AB_CDEF, 8'hFF, 64'h0, 64'h8123_4567_89AB_CDEF);
    do64("lw64", 1, 3'd2, 64'hC, 64'h0, 64'h8123_4567_89AB_CDEF, 8'hF0, 64'h0, 64'hFFFF_FFFF_8123_4567);
    do64("lwu64", 1, 3'd6, 64'hC, 64'h0, 64'h8123_4567_89AB_CDEF, 8'hF0, 64'h0, 64'h0000_0000_8123_4567);
    do64("sw64", 0, 3'd2, 64'h14, 64'hDEAD_BEEF, 64'h0, 8'hF0, 64'hDEAD_BEEF_0000_0000, 64'h0);

    // LH at 0x1002, response on the third request cycle.
    @(negedge clk); req32(1, 1, 0, 3'd1, 32'h1002, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); req32(0, 0, 0, 0, 0, 0);
      b.mem_resp_d = (i == 2); b.mem_rdata_d = 32'h8001_1234;
      #2 chk("lh_r", b.mem_r_d, 1);
      chk("lh_addr", b.mem_addr_d, 32'h1000);
      chk("lh_be", b.mem_byte_en_d, 4'b1100);
    end
    @(negedge clk); b.mem_resp_d = 0;
    #2 chk("lh_r_drop", b.mem_r_d, 0);
    chk("lh_rdy", b.mem_rdy, 1);
    chk("lh_ld", b.load_data, 32'hFFFF_8001);

    // SB at 0x1003.
    @(negedge clk); req32(1, 0, 1, 3'd0, 32'h1003, 32'h0000_00A5);
    @(negedge clk); req32(0, 0, 0, 0, 0, 0); b.mem_resp_d = 1;
    #2 chk("sb_w", b.mem_w_d, 1);
    chk("sb_be", b.mem_byte_en_d, 4'b1000);
    chk("sb_wdata", b.mem_wdata_d, 32'hA500_0000);
    chk("sb_addr", b.mem_addr_d, 32'h1000);
    @(negedge clk); b.mem_resp_d = 0;
    #2 chk("sb_rdy", b.mem_rdy, 1);
    chk("sb_ld", b.load_data, 0);

    // Misaligned LW, then illegal width.
    @(negedge clk); req32(1, 1, 0, 3'd2, 32'h1001, 0);
    @(negedge clk); req32(0, 0, 0, 0, 0, 0);
    #2 chk("lwmis_r", b.mem_r_d, 0);
    chk("lwmis_rdy", b.mem_rdy, 1);
    chk("lwmis_exc", b.exc, 1);
    chk("lwmis_code", b.exc_code, 2'b01);
    @(negedge clk); req32(1, 1, 0, 3'd7, 32'h1000, 0);
    @(negedge clk); req32(0, 0, 0, 0, 0, 0);
    #2 chk("ill_code", b.exc_code, 2'b11);
    chk("ill_r", b.mem_r_d, 0);

    // Held result, then zero-bubble handoff to an LBU.
    @(negedge clk); req32(1, 1, 0, 3'd2, 32'h3000, 0); b.wb_ready = 0;
    @(negedge clk); req32(0, 0, 0, 0, 0, 0); b.mem_resp_d = 1; b.mem_rdata_d = 32'h1234_5678;
    @(negedge clk); b.mem_resp_d = 0;
    for (int i = 0; i < 4; i++) begin
      #2 chk("hold_ld", b.load_data, 32'h1234_5678);
      chk("hold_rdy", b.mem_rdy, 1);
      @(negedge clk);
    end
    b.wb_ready = 1; req32(1, 1, 0, 3'd4, 32'h2001, 0);
    #2 chk("handoff_ready", b.req_ready, 1);
    @(negedge clk); req32(0, 0, 0, 0, 0, 0); b.mem_resp_d = 1; b.mem_rdata_d = 32'h0000_F000;
    #2 chk("handoff_r", b.mem_r_d, 1);
    @(negedge clk); b.mem_resp_d = 0;
    #2 chk("lbu_rdy", b.mem_rdy, 1);
    chk("lbu_ld", b.load_data, 32'h0000_00F0);

    // Flush in the second access cycle; response two cycles later.
    @(negedge clk); req32(1, 1, 0, 3'd2, 32'h4000, 0);
    @(negedge clk); req32(0, 0, 0, 0, 0, 0);
    #2 chk("fl_r1", b.mem_r_d, 1);
    @(negedge clk); b.flush = 1;
    #2 chk("fl_r2", b.mem_r_d, 1);
    @(negedge clk); b.flush = 0;
    #2 chk("fl_r3", b.mem_r_d, 1);
    @(negedge clk); b.mem_resp_d = 1;
    #2 chk("fl_r4", b.mem_r_d, 1);
    @(negedge clk); b.mem_resp_d = 0;
    #2 chk("fl_rdy", b.mem_rdy, 0);
    chk("fl_ready", b.req_ready, 1);
    chk("fl_r_off", b.mem_r_d, 0);

    // Reset in the middle of an access, followed by a stray response.
    @(negedge clk); req32(1, 1, 0, 3'd2, 32'h5000, 0);
    @(negedge clk); req32(0, 0, 0, 0, 0, 0);
    #2 chk("mr_r", b.mem_r_d, 1);
    @(negedge clk); rst_n = 0;
    #2 chk("mr_r_rst", b.mem_r_d, 0);
    chk("mr_addr_rst", b.mem_addr_d, 0);
    chk("mr_ready_rst", b.req_ready, 0);
    @(negedge clk);
    @(negedge clk); rst_n = 1;
    @(negedge clk); b.mem_resp_d = 1;
    @(negedge clk); b.mem_resp_d = 0;
    #2 chk("mr_stray_rdy", b.mem_rdy, 0);
    chk("mr_ready", b.req_ready, 1);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      int rw;
      @(negedge clk);
      rw = int'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 399) != 0);
      req32($urandom_range(0, 1) == 1, rw[0], rw[1], 3'($urandom_range(0, 7)),
            $urandom & 32'h0000_FFFF, $urandom);
      b.flush = ($urandom_range(0, 19) == 0);
      b.wb_ready = ($urandom_range(0, 2) != 0);
      b.mem_resp_d = ($urandom_range(0, 2) == 0);
      b.mem_rdata_d = $urandom;
    end
    @(negedge clk);
    rst_n = 1; req32(0, 0, 0, 0, 0, 0); b.flush = 0; b.mem_resp_d = 0;
    repeat (3) @(negedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
